seq_pattern_gen: RTL and testbench

Serial bit-pattern transmitter. It captures a PAT_W-bit pattern and a repeat count on a start pulse, then shifts the pattern out MSB-first, one bit per clk, for the requested number of repetitions. It is the stimulus and source side for the serial sequence-detector blocks in this design, and drives their din input directly.

---
 rtl/seq_pattern_gen.sv | 237 +++++++++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
// ---------------------------------------------------------------------------
// seq_pattern_gen
//   Serial bit-pattern transmitter. On an accepted start it captures a
//   PAT_W-bit pattern and a repeat count, then shifts the pattern out
//   MSB-first, one bit per clock, for repeat_n repetitions. It feeds the
//   din input of the serial sequence-detector blocks.
//
//   Optional build macro: SEQ_GEN_GAP_EN
//     Defined   : GAP_CYC idle cycles are inserted between repetitions.
//     Undefined : repetitions are strictly back-to-back (no GAP logic).
//
// Parameters
//   PAT_W    pattern length in bits (2..16)
//   CNT_W    width of the repeat count
//   GAP_CYC  idle cycles between repetitions (1..15, gap build only)
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active low
//   start        in   run request, sampled only in IDLE
//   pattern      in   PAT_W bits to send, captured on accepted start
//   repeat_n     in   repetition count, captured on accepted start
//   abort        in   synchronous cancel, any state, priority over start
//   dout         out  serial data (0 whenever dout_vld is 0)
//   dout_vld     out  dout carries a pattern bit this cycle
//   frame_start  out  high with the MSB of every repetition
//   busy         out  high while shifting (and in gaps)
//   done         out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module seq_pattern_gen #(
  parameter int PAT_W   = 5,
  parameter int CNT_W   = 8,
  parameter int GAP_CYC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic             abort,
  output logic             dout,
  output logic             dout_vld,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int               BW       = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BW-1:0]    LAST_BIT = BW'(PAT_W - 1);
  localparam logic [BW-1:0]    BIT_ONE  = BW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Reject out-of-range configurations at elaboration time.
  if ((PAT_W < 2) || (PAT_W > 16) || (GAP_CYC < 1) || (GAP_CYC > 15)) begin : g_bad_cfg
    $error("seq_pattern_gen: parameter out of legal range");
  end

`ifdef SEQ_GEN_GAP_EN
  localparam int            GAP_W     = 4;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd3
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;       // captured pattern, reloaded per repetition
  logic [PAT_W-1:0] sh_q, sh_d;         // remaining bits of current repetition, MSB next
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d; // index of the bit currently on dout
  logic [CNT_W-1:0] rem_q, rem_d;       // repetitions not yet finished
  logic             dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic             frame_start_q, frame_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SEQ_GEN_GAP_EN
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
`endif

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      pat_q         <= '0;
      sh_q          <= '0;
      bit_cnt_q     <= '0;
      rem_q         <= '0;
      dout_q        <= 1'b0;
      dout_vld_q    <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef SEQ_GEN_GAP_EN
      gap_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      sh_q          <= sh_d;
      bit_cnt_q     <= bit_cnt_d;
      rem_q         <= rem_d;
      dout_q        <= dout_d;
      dout_vld_q    <= dout_vld_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
`ifdef SEQ_GEN_GAP_EN
      gap_cnt_q     <= gap_cnt_d;
`endif
    end
  end

  // Next-state and next-output logic; outputs default to their idle values.
  always_comb begin
    state_d       = state_q;
    pat_d         = pat_q;
    sh_d          = sh_q;
    bit_cnt_d     = bit_cnt_q;
    rem_d         = rem_q;
    dout_d        = 1'b0;
    dout_vld_d    = 1'b0;
    frame_start_d = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
`ifdef SEQ_GEN_GAP_EN
    gap_cnt_d     = gap_cnt_q;
`endif

    if (abort) begin
      // Cancel: back to the reset picture, no done pulse.
      state_d   = S_IDLE;
      pat_d     = '0;
      sh_d      = '0;
      bit_cnt_d = '0;
      rem_d     = '0;
`ifdef SEQ_GEN_GAP_EN
      gap_cnt_d = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pat_d     = pattern;
            rem_d     = repeat_n;
            bit_cnt_d = '0;
            if (repeat_n == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              // First bit appears in the cycle right after the accepting edge.
              state_d       = S_SHIFT;
              dout_d        = pattern[PAT_W-1];
              sh_d          = {pattern[PAT_W-2:0], 1'b0};
              dout_vld_d    = 1'b1;
              frame_start_d = 1'b1;
              busy_d        = 1'b1;
            end
          end else begin
            state_d = S_IDLE;
          end
        end

        S_SHIFT: begin
          if (bit_cnt_q == LAST_BIT) begin
            // Last bit of this repetition is on dout now.
            rem_d     = rem_q - CNT_ONE;
            bit_cnt_d = '0;
            if (rem_q == CNT_ONE) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
`ifdef SEQ_GEN_GAP_EN
              state_d   = S_GAP;
              gap_cnt_d = GAP_LOAD;
              busy_d    = 1'b1;
`else
              state_d       = S_SHIFT;
              dout_d        = pat_q[PAT_W-1];
              sh_d          = {pat_q[PAT_W-2:0], 1'b0};
              dout_vld_d    = 1'b1;
              frame_start_d = 1'b1;
              busy_d        = 1'b1;
`endif
            end
          end else begin
            bit_cnt_d  = bit_cnt_q + BIT_ONE;
            dout_d     = sh_q[PAT_W-1];
            sh_d       = {sh_q[PAT_W-2:0], 1'b0};
            dout_vld_d = 1'b1;
            busy_d     = 1'b1;
          end
        end

`ifdef SEQ_GEN_GAP_EN
        S_GAP: begin
          if (gap_cnt_q == '0) begin
            state_d       = S_SHIFT;
            dout_d        = pat_q[PAT_W-1];
            sh_d          = {pat_q[PAT_W-2:0], 1'b0};
            dout_vld_d    = 1'b1;
            frame_start_d = 1'b1;
            busy_d        = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q - 4'd1;
            busy_d    = 1'b1;
          end
        end
`endif

        S_DONE: begin
          // start is deliberately not looked at here.
          state_d = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign dout        = dout_q;
  assign dout_vld    = dout_vld_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_gen
//   Directed bench for seq_pattern_gen (default parameters). Outputs are
//   packed as {dout, dout_vld, frame_start, busy, done} and compared 1 ns
//   after each rising edge against hand-derived values.
// ---------------------------------------------------------------------------
module tb_seq_pattern_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] pattern;
  logic [7:0] repeat_n;
  logic       abort;
  logic       dout;
  logic       dout_vld;
  logic       frame_start;
  logic       busy;
  logic       done;

  int checks;
  int errors;

  seq_pattern_gen dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pattern     (pattern),
    .repeat_n    (repeat_n),
    .abort       (abort),
    .dout        (dout),
    .dout_vld    (dout_vld),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the packed output vector against an expected value.
  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {dout, dout_vld, frame_start, busy, done};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected vector for a shifted pattern bit.
  function automatic logic [4:0] bit_vec(input logic b, input logic fs);
    return {b, 1'b1, fs, 1'b1, 1'b0};
  endfunction

  localparam logic [4:0] IDLE_V = 5'b00000;
  localparam logic [4:0] DONE_V = 5'b00001;
  localparam logic [4:0] GAP_V  = 5'b00010;

  initial begin
    logic [4:0] p;
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    start    = 1'b0;
    pattern  = 5'b00000;
    repeat_n = 8'd0;
    abort    = 1'b0;

    // Reset state.
    #12;
    chk("reset", IDLE_V);
    rst = 1'b1;
    tick();
    chk("idle_after_reset", IDLE_V);

    // 1: single repetition of 10010.
    p = 5'b10010;
    pattern = p; repeat_n = 8'd1; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t1_bit%0d", k), bit_vec(p[4-k], (k == 0)));
      tick();
    end
    chk("t1_done", DONE_V);
    tick();
    chk("t1_idle", IDLE_V);

    // 2: three repetitions.
    tick();
    pattern = p; repeat_n = 8'd3; start = 1'b1;
    tick(); start = 1'b0;
`ifdef SEQ_GEN_GAP_EN
    for (int off = 0; off < 21; off++) begin
      if ((off % 8) < 5)
        chk($sformatf("t2_off%0d", off), bit_vec(p[4-(off%8)], ((off % 8) == 0)));
      else
        chk($sformatf("t2_gap%0d", off), GAP_V);
      tick();
    end
`else
    for (int off = 0; off < 15; off++) begin
      chk($sformatf("t2_off%0d", off), bit_vec(p[4-(off%5)], ((off % 5) == 0)));
      tick();
    end
`endif
    chk("t2_done", DONE_V);
    tick();
    chk("t2_idle", IDLE_V);

    // 3: repeat_n = 0 gives only a done pulse.
    pattern = 5'b11111; repeat_n = 8'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("t3_done", DONE_V);
    tick();
    chk("t3_idle", IDLE_V);

    // 4: inputs changed and start re-pulsed mid-run are ignored; start in DONE ignored.
    pattern = p; repeat_n = 8'd1; start = 1'b1;
    tick(); start = 1'b0;
    chk("t4_bit0", bit_vec(p[4], 1'b1));
    tick();
    chk("t4_bit1", bit_vec(p[3], 1'b0));
    pattern = 5'b01101; repeat_n = 8'd2; start = 1'b1;
    tick(); start = 1'b0;
    chk("t4_bit2", bit_vec(p[2], 1'b0));
    tick();
    chk("t4_bit3", bit_vec(p[1], 1'b0));
    tick();
    chk("t4_bit4", bit_vec(p[0], 1'b0));
    tick();
    chk("t4_done", DONE_V);
    start = 1'b1;
    tick(); start = 1'b0;
    chk("t4_start_in_done", IDLE_V);
    tick();
    chk("t4_idle", IDLE_V);

    // 5: abort at offset 3, then abort beats start, then a fresh run.
    pattern = p; repeat_n = 8'd2; start = 1'b1;
    tick(); start = 1'b0;
    chk("t5_bit0", bit_vec(p[4], 1'b1));
    tick(); tick();
    chk("t5_bit2", bit_vec(p[2], 1'b0));
    abort = 1'b1;
    tick(); abort = 1'b0;
    chk("t5_aborted", IDLE_V);
    abort = 1'b1; start = 1'b1;
    tick(); abort = 1'b0; start = 1'b0;
    chk("t5_abort_prio", IDLE_V);
    tick();
    chk("t5_idle", IDLE_V);
    p = 5'b11001;
    pattern = p; repeat_n = 8'd1; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t5_fresh%0d", k), bit_vec(p[4-k], (k == 0)));
      tick();
    end
    chk("t5_done", DONE_V);
    tick();

    // 6: asynchronous reset mid-stream.
    p = 5'b10110;
    pattern = p; repeat_n = 8'd4; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("t6_off%0d", k), bit_vec(p[4-(k%5)], ((k % 5) == 0)));
      tick();
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_async_rst", IDLE_V);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t6_post%0d", k), IDLE_V);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
